// File: rtl/writeback_top_if.sv
// Memory-to-writeback bus: the memory-access stage drives this bundle and the
// writeback stage samples it.
interface writeback_top_if #(
    parameter int XLEN = 32
);
    logic            mw_vld;
    logic [XLEN-1:0] mw_dat;
    logic [31:0]     mw_inst;
    logic [31:0]     mw_pc;
    logic [1:0]      mw_addr_lo;

    modport master (output mw_vld, mw_dat, mw_inst, mw_pc, mw_addr_lo);
    modport slave  (input  mw_vld, mw_dat, mw_inst, mw_pc, mw_addr_lo);
endinterface

// File: rtl/writeback_top.sv
// Writeback stage: registers the memory-stage result, formats load data,
// commits rd into the architectural register file and serves the two decode
// read ports with write-through bypass.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter;
// without it wb_instret is tied to zero and no counter flops exist.
module writeback_top #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_top_if.slave   mw,
    input  logic             wb_stall,
    input  logic             wb_flush,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    output logic [XLEN-1:0]  id_rd1,
    output logic [XLEN-1:0]  id_rd2,
    output logic             wb_fwd_we,
    output logic [4:0]       wb_fwd_dst,
    output logic [XLEN-1:0]  wb_fwd_dat,
    output logic [63:0]      wb_instret
);
    // Opcode values shared with the rest of the pipeline (utils_top encodings).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Stage registers
    logic            vld_q, vld_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     pc_q, pc_d;
    logic [XLEN-1:0] dat_q, dat_d;
    logic [1:0]      lo_q, lo_d;

    logic [XLEN-1:0] rf_q [NREG];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign opcode = inst_q[6:0];
    assign funct3 = inst_q[14:12];

    // pc and the upper instruction bits travel with the stage but are not
    // consumed here; folding them keeps them visible without driving logic.
    logic unused_stage;
    assign unused_stage = ^{pc_q, inst_q[31:15]};

    // Next stage state: stall holds everything (and so beats flush).
    always_comb begin
        vld_d  = vld_q;
        inst_d = inst_q;
        pc_d   = pc_q;
        dat_d  = dat_q;
        lo_d   = lo_q;
        if (!wb_stall) begin
            vld_d  = mw.mw_vld & ~wb_flush;
            inst_d = mw.mw_inst;
            pc_d   = mw.mw_pc;
            dat_d  = mw.mw_dat;
            lo_d   = mw.mw_addr_lo;
        end
    end

    // Stage register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            inst_q <= '0;
            pc_q   <= '0;
            dat_q  <= '0;
            lo_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            inst_q <= inst_d;
            pc_q   <= pc_d;
            dat_q  <= dat_d;
            lo_q   <= lo_d;
        end
    end

    // Load lane selection; a misaligned halfword still picks the half chosen
    // by addr_lo[1].
    always_comb begin
        byte_sel = dat_q[7:0];
        case (lo_q)
            2'd0:    byte_sel = dat_q[7:0];
            2'd1:    byte_sel = dat_q[15:8];
            2'd2:    byte_sel = dat_q[23:16];
            default: byte_sel = dat_q[31:24];
        endcase
        half_sel = lo_q[1] ? dat_q[31:16] : dat_q[15:0];
    end

    // Load formatting; non-loads and unknown funct3 pass the word through.
    always_comb begin
        wb_fwd_dat = dat_q;
        if (opcode == OP_LOAD) begin
            case (funct3)
                3'b000:  wb_fwd_dat = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                3'b001:  wb_fwd_dat = {{(XLEN-16){half_sel[15]}}, half_sel};
                3'b100:  wb_fwd_dat = {{(XLEN-8){1'b0}}, byte_sel};
                3'b101:  wb_fwd_dat = {{(XLEN-16){1'b0}}, half_sel};
                default: wb_fwd_dat = dat_q;
            endcase
        end
    end

    assign wb_fwd_dst = inst_q[11:7];
    assign wb_fwd_we  = vld_q & ~wb_stall & (wb_fwd_dst != 5'd0)
                      & (opcode != OP_STORE) & (opcode != OP_BRANCH);

    // Register file: cleared on reset, reset beats any pending commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_fwd_we) begin
            rf_q[wb_fwd_dst] <= wb_fwd_dat;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(
        input logic [4:0]      rs,
        input logic            we,
        input logic [4:0]      dst,
        input logic [XLEN-1:0] fdat,
        input logic [XLEN-1:0] rdat
    );
        if (rs == 5'd0)             return '0;
        else if (we && rs == dst)   return fdat;
        else                        return rdat;
    endfunction

    // Decode read ports with write-through bypass of this cycle's commit.
    always_comb begin
        id_rd1 = rd_port(id_rs1, wb_fwd_we, wb_fwd_dst, wb_fwd_dat, rf_q[id_rs1]);
        id_rd2 = rd_port(id_rs2, wb_fwd_we, wb_fwd_dst, wb_fwd_dat, rf_q[id_rs2]);
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Every retiring stage slot counts, stores and branches included.
    always_comb begin
        instret_d = instret_q;
        if (vld_q && !wb_stall) instret_d = instret_q + 64'd1;
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign wb_instret = instret_q;
`else
    assign wb_instret = '0;
`endif
endmodule

// File: tb/tb_writeback_top.sv
// Directed bench for writeback_top: reset, commit/bypass, load formatting,
// no-write opcodes, stall/flush, mid-operation reset and instret.
module tb_writeback_top;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_stall, wb_flush;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rd1, id_rd2;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_dst;
    logic [31:0] wb_fwd_dat;
    logic [63:0] wb_instret;

    int n_chk  = 0;
    int n_fail = 0;

    writeback_top_if #(.XLEN(32)) mw ();

    writeback_top #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mw         (mw.slave),
        .wb_stall   (wb_stall),
        .wb_flush   (wb_flush),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .wb_fwd_we  (wb_fwd_we),
        .wb_fwd_dst (wb_fwd_dst),
        .wb_fwd_dat (wb_fwd_dat),
        .wb_instret (wb_instret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_REG  = 7'b0110011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3);
        return {17'h0, f3, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid instruction for a single capture edge.
    task automatic issue(input logic [31:0] inst, input logic [31:0] dat, input logic [1:0] lo);
        mw.mw_inst    = inst;
        mw.mw_dat     = dat;
        mw.mw_addr_lo = lo;
        mw.mw_pc      = 32'h0000_1000;
        mw.mw_vld     = 1'b1;
        tick();
        mw.mw_vld     = 1'b0;
        #1;
    endtask

    logic [63:0] exp_ret;

    initial begin
        rst_n = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
        id_rs1 = '0; id_rs2 = '0;
        mw.mw_vld = 1'b0; mw.mw_dat = '0; mw.mw_inst = '0; mw.mw_pc = '0; mw.mw_addr_lo = '0;

        // Reset for two cycles, then every register reads zero.
        tick(); tick();
        chk("rst_we", 64'(wb_fwd_we), 64'd0);
        chk("rst_instret", wb_instret, 64'd0);
        for (int i = 0; i < 32; i++) begin
            id_rs1 = 5'(i); id_rs2 = 5'(31 - i);
            #1;
            chk("rst_rd1", 64'(id_rd1), 64'd0);
            chk("rst_rd2", 64'(id_rd2), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // ADDI x5 commit with same-cycle bypass on both ports.
        issue(32'h00A00293, 32'h0000000A, 2'd0);
        id_rs1 = 5'd5; id_rs2 = 5'd5; #1;
        chk("addi_we", 64'(wb_fwd_we), 64'd1);
        chk("addi_dst", 64'(wb_fwd_dst), 64'd5);
        chk("addi_dat", 64'(wb_fwd_dat), 64'h0000000A);
        chk("byp_rd1", 64'(id_rd1), 64'h0000000A);
        chk("byp_rd2", 64'(id_rd2), 64'h0000000A);
        tick();
        chk("idle_we", 64'(wb_fwd_we), 64'd0);
        chk("rf_x5", 64'(id_rd1), 64'h0000000A);

        // Load formatting on 0x80FF7F01.
        issue(enc(OPC_LOAD, 5'd6, 3'b000), 32'h80FF7F01, 2'd3);
        chk("lb3", 64'(wb_fwd_dat), 64'hFFFFFF80);
        issue(enc(OPC_LOAD, 5'd6, 3'b100), 32'h80FF7F01, 2'd3);
        chk("lbu3", 64'(wb_fwd_dat), 64'h00000080);
        issue(enc(OPC_LOAD, 5'd6, 3'b001), 32'h80FF7F01, 2'd2);
        chk("lh2", 64'(wb_fwd_dat), 64'hFFFF80FF);
        issue(enc(OPC_LOAD, 5'd6, 3'b101), 32'h80FF7F01, 2'd2);
        chk("lhu2", 64'(wb_fwd_dat), 64'h000080FF);
        issue(enc(OPC_LOAD, 5'd6, 3'b000), 32'h80FF7F01, 2'd0);
        chk("lb0", 64'(wb_fwd_dat), 64'h00000001);
        issue(enc(OPC_LOAD, 5'd6, 3'b000), 32'h80FF7F01, 2'd1);
        chk("lb1", 64'(wb_fwd_dat), 64'h0000007F);
        issue(enc(OPC_LOAD, 5'd6, 3'b001), 32'h80FF7F01, 2'd0);
        chk("lh0", 64'(wb_fwd_dat), 64'h00007F01);
        issue(enc(OPC_LOAD, 5'd6, 3'b001), 32'h80FF7F01, 2'd3);
        chk("lh_mis3", 64'(wb_fwd_dat), 64'hFFFF80FF);
        issue(enc(OPC_LOAD, 5'd6, 3'b011), 32'h80FF7F01, 2'd3);
        chk("ld_f3_011", 64'(wb_fwd_dat), 64'h80FF7F01);
        issue(enc(OPC_REG, 5'd6, 3'b000), 32'h80FF7F01, 2'd3);
        chk("alu_pass", 64'(wb_fwd_dat), 64'h80FF7F01);
        issue(enc(OPC_LOAD, 5'd6, 3'b010), 32'h80FF7F01, 2'd3);
        id_rs2 = 5'd6; #1;
        chk("lw", 64'(wb_fwd_dat), 64'h80FF7F01);
        chk("lw_byp", 64'(id_rd2), 64'h80FF7F01);
        tick();
        chk("rf_x6", 64'(id_rd2), 64'h80FF7F01);

        // Stores, branches and rd=0 never write.
        issue(enc(OPC_ST, 5'd9, 3'b010), 32'h12345678, 2'd0);
        chk("st_we", 64'(wb_fwd_we), 64'd0);
        issue(enc(OPC_BR, 5'd9, 3'b000), 32'h12345678, 2'd0);
        chk("br_we", 64'(wb_fwd_we), 64'd0);
        issue(enc(OPC_IMM, 5'd0, 3'b000), 32'hDEADBEEF, 2'd0);
        id_rs1 = 5'd0; id_rs2 = 5'd9; #1;
        chk("x0_we", 64'(wb_fwd_we), 64'd0);
        chk("x0_byp", 64'(id_rd1), 64'd0);
        tick();
        chk("x0_rf", 64'(id_rd1), 64'd0);
        chk("x9_rf", 64'(id_rd2), 64'd0);

        // Stall holds ADDI x7 for three cycles, then one commit.
        issue(enc(OPC_IMM, 5'd7, 3'b000), 32'h00000077, 2'd0);
        wb_stall = 1'b1;
        mw.mw_inst = enc(OPC_IMM, 5'd8, 3'b000); mw.mw_dat = 32'h55; mw.mw_vld = 1'b1;
        id_rs1 = 5'd7; id_rs2 = 5'd8; #1;
        for (int c = 0; c < 3; c++) begin
            wb_flush = (c == 1);
            chk("stall_we", 64'(wb_fwd_we), 64'd0);
            chk("stall_dst", 64'(wb_fwd_dst), 64'd7);
            chk("stall_dat", 64'(wb_fwd_dat), 64'h77);
            tick();
            chk("stall_x7", 64'(id_rd1), 64'd0);
        end
        wb_stall = 1'b0; wb_flush = 1'b0; mw.mw_vld = 1'b0; #1;
        chk("rel_we", 64'(wb_fwd_we), 64'd1);
        chk("rel_dst", 64'(wb_fwd_dst), 64'd7);
        tick();
        chk("rel_once", 64'(wb_fwd_we), 64'd0);
        chk("rel_x7", 64'(id_rd1), 64'h77);
        chk("rel_x8", 64'(id_rd2), 64'd0);

        // Flushed capture is never committed.
        wb_flush = 1'b1;
        issue(enc(OPC_IMM, 5'd10, 3'b000), 32'h00001010, 2'd0);
        wb_flush = 1'b0;
        id_rs1 = 5'd10; #1;
        chk("flush_we", 64'(wb_fwd_we), 64'd0);
        tick();
        chk("flush_x10", 64'(id_rd1), 64'd0);

        // Reset with a commit pending: dropped, and x5 is cleared.
        issue(enc(OPC_IMM, 5'd12, 3'b000), 32'h00000C0C, 2'd0);
        chk("pend_we", 64'(wb_fwd_we), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        id_rs1 = 5'd12; id_rs2 = 5'd5; #1;
        chk("mid_rst_we", 64'(wb_fwd_we), 64'd0);
        chk("mid_rst_x12", 64'(id_rd1), 64'd0);
        chk("mid_rst_x5", 64'(id_rd2), 64'd0);
        chk("mid_rst_ret", wb_instret, 64'd0);

        // Ten valid instructions, two stores, one held two stall cycles.
        for (int k = 0; k < 10; k++) begin
            mw.mw_inst = (k == 3 || k == 7) ? enc(OPC_ST, 5'd1, 3'b010)
                                            : enc(OPC_IMM, 5'd11, 3'b000);
            mw.mw_dat  = 32'(k);
            mw.mw_vld  = 1'b1;
            tick();
            if (k == 4) begin
                wb_stall = 1'b1;
                tick(); tick();
                wb_stall = 1'b0;
            end
        end
        mw.mw_vld = 1'b0;
`ifdef WB_INSTRET_EN
        exp_ret = 64'd9;
`else
        exp_ret = 64'd0;
`endif
        chk("instret_9", wb_instret, exp_ret);
        tick();
`ifdef WB_INSTRET_EN
        exp_ret = 64'd10;
`else
        exp_ret = 64'd0;
`endif
        chk("instret_10", wb_instret, exp_ret);
        tick();
        chk("instret_idle", wb_instret, exp_ret);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
